hazard_scoreboard: RTL
======================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised scoreboard hazard unit for the 5-stage MIPS pipeline; replaces fixed per-opcode compares.
//  Tracks pending GPR writes and HI/LO (mult/div) busy time with per-register countdowns.
//  Stalls the ID-stage instruction until its operands can be forwarded; drives PC write, IF/ID stall and ID/EX bubble.
//  Supports variable load latency, early (ID-stage) consumers such as branch/jr/jalr, a multi-cycle MDU and a stall counter.
// PARAMETERS
//  NREG        32  number of architectural GPRs tracked (r0 never tracked)
//  AW          5   register address width, log2(NREG)
//  LOAD_LAT    1   bubbles a normal consumer needs directly after a load
//  EARLY_EXTRA 1   extra bubbles for an ID-stage consumer (branch/jr) vs a normal one
//  MDU_LAT     4   cycles HI/LO stay busy after mult/div issue
//  CW          4   width of per-register countdown counters
//  SCW         16  width of stall performance counter
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  id_valid     in   1   ID holds a real instruction
//  id_rs/id_rt  in   AW  source register addresses
//  id_rs_used   in   1   rs is read
//  id_rt_used   in   1   rt is read
//  id_early     in   1   sources are consumed in ID (beq/bne/blez/bgtz/bltz/bgez/jr/jalr)
//  id_wr_en     in   1   instruction writes a GPR
//  id_wr_addr   in   AW  destination GPR
//  id_is_load   in   1   destination is written by a load
//  id_mdu_start in   1   mult/multu/div/divu
//  id_hilo_rd   in   1   mfhi/mflo
//  ex_flush     in   1   branch/jump redirect: kill the ID instruction this cycle
//  stall_clr    in   1   synchronous clear of stall_cnt
//  pc_we        out  1   PC write enable
//  ifid_stall   out  1   hold IF/ID register
//  idex_flush   out  1   insert bubble into ID/EX
//  stall_cause  out  2   0 none, 1 GPR hazard, 2 HI/LO busy, 3 both
//  stall_cnt    out  SCW saturating count of stall cycles
// BEHAVIOUR
//  - Reset (rst_n=0, async): all cnt_n/cnt_e/mdu_busy=0, stall_cnt=0; outputs pc_we=1, ifid_stall=0, idex_flush=0, stall_cause=0.
//  - Per reg r: cnt_n[r], cnt_e[r] (CW bits). Each cycle every nonzero counter decrements by 1; saturate at 0.
//  - gpr_haz = id_valid & ((id_rs_used & rs!=0 & C[rs]!=0) | (id_rt_used & rt!=0 & C[rt]!=0)).
//    C = cnt_e if id_early else cnt_n. Uses pre-edge counter values.
//  - mdu_haz = id_valid & (id_hilo_rd | id_mdu_start) & mdu_busy!=0.
//  - stall = (gpr_haz | mdu_haz) & ~ex_flush. Outputs are combinational:
//    pc_we=~stall, ifid_stall=stall, idex_flush=stall|ex_flush.
//  - issue = id_valid & ~stall & ~ex_flush. On issue with id_wr_en & wr_addr!=0:
//    load: cnt_n=LOAD_LAT, cnt_e=LOAD_LAT+EARLY_EXTRA; non-load: cnt_n=0, cnt_e=EARLY_EXTRA.
//    The loaded value overrides the decrement in that cycle.
//  - Issue with id_mdu_start: mdu_busy<=MDU_LAT.
//  - WAW: the newer writer overwrites counters; a same-cycle read of wr_addr uses the old counters.
//  - ex_flush dominates: no stall, no scoreboard load, bubble inserted. Counters keep decrementing.
//  - stall_cnt: +1 per stall cycle, saturates at all-ones. stall_clr wins over increment.
//  - Reset mid-stall: outputs return to reset values immediately; all hazards are forgotten.
// TESTING
//  lw r8; add r9,r8,r1 -> exactly 1 stall cycle (pc_we=0, idex_flush=1), add issues next cycle; stall_cnt=1.
//  lw r8; beq r8,r2 -> 2 stall cycles; addu r8; jr r8 -> 1 stall cycle; addu r8; add r9,r8 -> 0 stalls.
//  mult; mflo (MDU_LAT=4) -> mflo stalls 4 cycles with stall_cause=2, then issues; mult;mult same.
//  lw r8 stalled consumer with ex_flush=1 -> pc_we=1, idex_flush=1, no stall, cnt unchanged except decrement.
//  lw r8; lw r8 back-to-back then add r8 -> 1 stall; write to r0 then read r0 -> no stall.
//  rst_n low during a stall -> outputs at reset values within same cycle; stall_clr with stall -> stall_cnt=0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard that stalls the ID instruction
// until its GPR / HI-LO operands are forwardable; drives PC write, IF/ID stall, ID/EX bubble.
module hazard_scoreboard #(
    parameter int NREG        = 32,
    parameter int AW          = 5,
    parameter int LOAD_LAT    = 1,
    parameter int EARLY_EXTRA = 1,
    parameter int MDU_LAT     = 4,
    parameter int CW          = 4,
    parameter int SCW         = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           id_valid,
    input  logic [AW-1:0]  id_rs,
    input  logic [AW-1:0]  id_rt,
    input  logic           id_rs_used,
    input  logic           id_rt_used,
    input  logic           id_early,
    input  logic           id_wr_en,
    input  logic [AW-1:0]  id_wr_addr,
    input  logic           id_is_load,
    input  logic           id_mdu_start,
    input  logic           id_hilo_rd,
    input  logic           ex_flush,
    input  logic           stall_clr,
    output logic           pc_we,
    output logic           ifid_stall,
    output logic           idex_flush,
    output logic [1:0]     stall_cause,
    output logic [SCW-1:0] stall_cnt
);
    logic [CW-1:0]  cnt_n_q [NREG];
    logic [CW-1:0]  cnt_n_d [NREG];
    logic [CW-1:0]  cnt_e_q [NREG];
    logic [CW-1:0]  cnt_e_d [NREG];
    logic [CW-1:0]  mdu_busy_q, mdu_busy_d;
    logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CW-1:0]  c_rs, c_rt;
    logic           gpr_haz, mdu_haz, stall, issue, gpr_ld;

    always_comb begin
        c_rs    = id_early ? cnt_e_q[id_rs] : cnt_n_q[id_rs];
        c_rt    = id_early ? cnt_e_q[id_rt] : cnt_n_q[id_rt];
        gpr_haz = id_valid & ((id_rs_used & (id_rs != '0) & (c_rs != '0)) |
                              (id_rt_used & (id_rt != '0) & (c_rt != '0)));
        mdu_haz = id_valid & (id_hilo_rd | id_mdu_start) & (mdu_busy_q != '0);
        stall   = (gpr_haz | mdu_haz) & ~ex_flush;
        issue   = id_valid & ~stall & ~ex_flush;
        gpr_ld  = issue & id_wr_en & (id_wr_addr != '0);
        // r0 is never loaded, so its counters stay at their reset value of zero
        for (int i = 0; i < NREG; i++) begin
            cnt_n_d[i] = cnt_n_q[i] - CW'(cnt_n_q[i] != '0);
            cnt_e_d[i] = cnt_e_q[i] - CW'(cnt_e_q[i] != '0);
            if (gpr_ld && id_wr_addr == AW'(i)) begin
                cnt_n_d[i] = id_is_load ? CW'(LOAD_LAT) : '0;
                cnt_e_d[i] = id_is_load ? CW'(LOAD_LAT + EARLY_EXTRA) : CW'(EARLY_EXTRA);
            end
        end
        mdu_busy_d  = (issue & id_mdu_start) ? CW'(MDU_LAT) : mdu_busy_q - CW'(mdu_busy_q != '0);
        stall_cnt_d = stall_clr ? '0 : stall_cnt_q + SCW'(stall & ~(&stall_cnt_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_n_q     <= '{default: '0};
            cnt_e_q     <= '{default: '0};
            mdu_busy_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            cnt_n_q     <= cnt_n_d;
            cnt_e_q     <= cnt_e_d;
            mdu_busy_q  <= mdu_busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pc_we       = ~stall;
    assign ifid_stall  = stall;
    assign idex_flush  = stall | ex_flush;
    assign stall_cause = {mdu_haz & ~ex_flush, gpr_haz & ~ex_flush};
    assign stall_cnt   = stall_cnt_q;
endmodule
